// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl
// Sequencer and HI/LO register file that sits between the multicycle control
// unit and the iterative MULT/DIV datapaths. One request is accepted at a
// time; MULT/DIV operands are latched and the unit start line is held high
// until the unit reports end (results captured into HI/LO) or the run
// exceeds TIMEOUT posedges (aborted, HI/LO untouched).
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   op_valid, op_sel    request strobe and opcode (00 MULT, 01 DIV, 10 MTHI, 11 MTLO)
//   rs_val, rt_val      operand A / operand B
//   op_ready, busy      request accepted when idle / MULT or DIV in flight
//   opa, opb            registered operands, held for the whole run
//   div_start/end/hi/lo    divider handshake and results
//   mult_start/end/hi/lo   multiplier handshake and results
//   hi, lo              architectural HI / LO
//   div_zero_exc        one-cycle pulse: DIV with zero divisor
//   timeout_err         one-cycle pulse: unit exceeded TIMEOUT
module hilo_md_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_sel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        op_ready,
    output logic        busy,
    output logic [31:0] opa,
    output logic [31:0] opb,
    output logic        div_start,
    input  logic        div_end,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        mult_start,
    input  logic        mult_end,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero_exc,
    output logic        timeout_err
);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN_DIV  = 2'b01,
        RUN_MULT = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       opa_q, opa_d;
    logic [31:0]       opb_q, opb_d;
    logic              div_start_q, div_start_d;
    logic              mult_start_q, mult_start_d;
    logic              div_zero_exc_q, div_zero_exc_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            hi_q           <= '0;
            lo_q           <= '0;
            opa_q          <= '0;
            opb_q          <= '0;
            div_start_q    <= 1'b0;
            mult_start_q   <= 1'b0;
            div_zero_exc_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            opa_q          <= opa_d;
            opb_q          <= opb_d;
            div_start_q    <= div_start_d;
            mult_start_q   <= mult_start_d;
            div_zero_exc_q <= div_zero_exc_d;
            timeout_err_q  <= timeout_err_d;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        opa_d          = opa_q;
        opb_d          = opb_q;
        div_start_d    = div_start_q;
        mult_start_d   = mult_start_q;
        div_zero_exc_d = 1'b0;
        timeout_err_d  = 1'b0;
        cnt_d          = cnt_q;

        unique case (state_q)
            IDLE: begin
                div_start_d  = 1'b0;
                mult_start_d = 1'b0;
                if (op_valid) begin
                    unique case (op_sel)
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        OP_DIV: begin
                            // A zero divisor is flagged here and the divider is
                            // never started, so HI/LO keep their old contents.
                            if (rt_val == 32'd0) begin
                                div_zero_exc_d = 1'b1;
                            end else begin
                                opa_d       = rs_val;
                                opb_d       = rt_val;
                                div_start_d = 1'b1;
                                cnt_d       = '0;
                                state_d     = RUN_DIV;
                            end
                        end
                        OP_MULT: begin
                            opa_d        = rs_val;
                            opb_d        = rt_val;
                            mult_start_d = 1'b1;
                            cnt_d        = '0;
                            state_d      = RUN_MULT;
                        end
                        default: ;
                    endcase
                end
            end

            RUN_DIV: begin
                cnt_d = cnt_q + CNT_ONE;
                // End is checked before the timeout so that an end arriving on
                // the last allowed edge still delivers its result.
                if (div_end) begin
                    hi_d        = div_hi;
                    lo_d        = div_lo;
                    div_start_d = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    div_start_d   = 1'b0;
                    state_d       = IDLE;
                end
            end

            RUN_MULT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (mult_end) begin
                    hi_d         = mult_hi;
                    lo_d         = mult_lo;
                    mult_start_d = 1'b0;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    mult_start_d  = 1'b0;
                    state_d       = IDLE;
                end
            end

            default: begin
                div_start_d  = 1'b0;
                mult_start_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    assign op_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign opa          = opa_q;
    assign opb          = opb_q;
    assign div_start    = div_start_q;
    assign mult_start   = mult_start_q;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign div_zero_exc = div_zero_exc_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Bench for hilo_md_ctrl: behavioural divider / multiplier models driven on
// negedge, requests driven and outputs sampled on negedge, expected HI/LO
// pairs kept in a queue and compared when each operation completes.
module tb_hilo_md_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op_sel;
    logic [31:0] rs_val, rt_val;
    logic        op_ready, busy;
    logic [31:0] opa, opb;
    logic        div_start, div_end;
    logic [31:0] div_hi, div_lo;
    logic        mult_start, mult_end;
    logic [31:0] mult_hi, mult_lo;
    logic [31:0] hi, lo;
    logic        div_zero_exc, timeout_err;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    int div_n  = 32;
    int mult_n = 5;
    bit hang   = 1'b0;
    int div_cnt  = 0;
    int mult_cnt = 0;

    hilo_md_ctrl #(.TIMEOUT(40), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_sel(op_sel), .rs_val(rs_val), .rt_val(rt_val),
        .op_ready(op_ready), .busy(busy), .opa(opa), .opb(opb),
        .div_start(div_start), .div_end(div_end), .div_hi(div_hi), .div_lo(div_lo),
        .mult_start(mult_start), .mult_end(mult_end), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .hi(hi), .lo(lo), .div_zero_exc(div_zero_exc), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Unit models: count negedges with start high, raise end after N of them.
    always @(negedge clk) begin
        if (div_start) begin
            div_cnt <= div_cnt + 1;
            div_end <= !hang && (div_cnt + 1 >= div_n);
        end else begin
            div_cnt <= 0;
            div_end <= 1'b0;
        end
        div_hi <= (opb != 32'd0) ? opa % opb : 32'd0;
        div_lo <= (opb != 32'd0) ? opa / opb : 32'd0;
    end

    always @(negedge clk) begin
        if (mult_start) begin
            mult_cnt <= mult_cnt + 1;
            mult_end <= !hang && (mult_cnt + 1 >= mult_n);
        end else begin
            mult_cnt <= 0;
            mult_end <= 1'b0;
        end
        {mult_hi, mult_lo} <= 64'($signed(opa) * $signed(opb));
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic issue(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op_sel   = sel;
        rs_val   = a;
        rt_val   = b;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Counts cycles with a start high until busy drops; also tracks overlap
    // of the two starts and operand stability.
    task automatic run_until_idle(input logic [31:0] a, input logic [31:0] b,
                                  output int starts, output int viol, output bit ok);
        starts = 0;
        viol   = 0;
        ok     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (div_start || mult_start) starts++;
            if (div_start && mult_start) viol++;
            if (opa !== a || opb !== b) viol++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op_valid = 1'b0; op_sel = 2'b00; rs_val = '0; rt_val = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, op_ready, div_start, mult_start, div_zero_exc, timeout_err} !== 6'b010000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 010000",
                     {busy, op_ready, div_start, mult_start, div_zero_exc, timeout_err});
        end
        total++;
        if ({hi, lo, opa, opb} !== 128'd0) begin
            bad++;
            $display("FAIL reset_data: hi=%h lo=%h opa=%h opb=%h want all 0", hi, lo, opa, opb);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div();
        int n, v; bit ok; logic [63:0] e;
        exp_hi = 32'd2; exp_lo = 32'd14;
        exp_q.push_back({exp_hi, exp_lo});
        issue(2'b01, 32'd100, 32'd7);
        run_until_idle(32'd100, 32'd7, n, v, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL div_done: busy never fell"); end
        total++;
        if (n !== 32) begin bad++; $display("FAIL div_start_len: got %0d want 32", n); end
        total++;
        if (v !== 0) begin bad++; $display("FAIL div_hold: %0d overlap/operand violations want 0", v); end
        e = exp_q.pop_front();
        total++;
        if ({hi, lo} !== e) begin bad++; $display("FAIL div_result: got %h want %h", {hi, lo}, e); end
        total++;
        if (op_ready !== 1'b1 || div_start !== 1'b0) begin
            bad++; $display("FAIL div_idle: op_ready=%b div_start=%b want 1 0", op_ready, div_start);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int starts = 0; logic [63:0] e;
        issue(2'b10, 32'hAAAA_AAAA, 32'd0);
        issue(2'b11, 32'h5555_5555, 32'd0);
        exp_hi = 32'hAAAA_AAAA; exp_lo = 32'h5555_5555;
        exp_q.push_back({exp_hi, exp_lo});
        issue(2'b01, 32'd5, 32'd0);
        total++;
        if (div_zero_exc !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL dz_pulse: exc=%b busy=%b want 1 0", div_zero_exc, busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (div_start) starts++;
            @(negedge clk);
            if (i == 0) begin
                total++;
                if (div_zero_exc !== 1'b0) begin bad++; $display("FAIL dz_width: exc=%b want 0", div_zero_exc); end
            end
        end
        total++;
        if (starts !== 0) begin bad++; $display("FAIL dz_nostart: div_start high %0d cycles want 0", starts); end
        e = exp_q.pop_front();
        total++;
        if ({hi, lo} !== e) begin bad++; $display("FAIL dz_hilo: got %h want %h", {hi, lo}, e); end
    endtask

    task automatic test_mult_busy_ignore();
        int n, v; bit ok; logic [63:0] e;
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFE;
        exp_q.push_back({exp_hi, exp_lo});
        issue(2'b00, 32'hFFFF_FFFF, 32'd2);
        total++;
        if (op_ready !== 1'b0 || busy !== 1'b1 || mult_start !== 1'b1) begin
            bad++; $display("FAIL mult_busy: ready=%b busy=%b mstart=%b want 0 1 1", op_ready, busy, mult_start);
        end
        issue(2'b10, 32'hDEAD_BEEF, 32'd0);
        run_until_idle(32'hFFFF_FFFF, 32'd2, n, v, ok);
        total++;
        if (!ok || v !== 0) begin bad++; $display("FAIL mult_run: ok=%b viol=%0d want 1 0", ok, v); end
        e = exp_q.pop_front();
        total++;
        if ({hi, lo} !== e) begin bad++; $display("FAIL mult_result: got %h want %h", {hi, lo}, e); end
        repeat (2) @(negedge clk);
        total++;
        if ({hi, lo} !== e || busy !== 1'b0) begin
            bad++; $display("FAIL mult_ignore: hi/lo=%h busy=%b want %h 0", {hi, lo}, busy, e);
        end
    endtask

    task automatic test_timeout();
        int n, v; bit ok; logic [63:0] e;
        hang = 1'b1;
        exp_q.push_back({exp_hi, exp_lo});
        issue(2'b01, 32'd9, 32'd3);
        run_until_idle(32'd9, 32'd3, n, v, ok);
        total++;
        if (!ok || n !== 40) begin bad++; $display("FAIL to_len: ok=%b start cycles=%0d want 1 40", ok, n); end
        total++;
        if (timeout_err !== 1'b1 || div_start !== 1'b0) begin
            bad++; $display("FAIL to_pulse: err=%b dstart=%b want 1 0", timeout_err, div_start);
        end
        e = exp_q.pop_front();
        total++;
        if ({hi, lo} !== e) begin bad++; $display("FAIL to_hilo: got %h want %h", {hi, lo}, e); end
        @(negedge clk);
        total++;
        if (timeout_err !== 1'b0 || op_ready !== 1'b1) begin
            bad++; $display("FAIL to_after: err=%b ready=%b want 0 1", timeout_err, op_ready);
        end
        hang = 1'b0;
    endtask

    task automatic test_end_and_timeout();
        int n, v; bit ok; logic [63:0] e;
        mult_n = 40;
        exp_hi = 32'd0; exp_lo = 32'd12;
        exp_q.push_back({exp_hi, exp_lo});
        issue(2'b00, 32'd3, 32'd4);
        run_until_idle(32'd3, 32'd4, n, v, ok);
        total++;
        if (!ok || n !== 40 || timeout_err !== 1'b0) begin
            bad++; $display("FAIL end_wins: ok=%b cycles=%0d err=%b want 1 40 0", ok, n, timeout_err);
        end
        e = exp_q.pop_front();
        total++;
        if ({hi, lo} !== e) begin bad++; $display("FAIL end_wins_hilo: got %h want %h", {hi, lo}, e); end
        mult_n = 5;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int busy_seen = 0; logic [63:0] e;
        exp_hi = 32'h1234; exp_lo = 32'h5678;
        exp_q.push_back({exp_hi, exp_lo});
        op_valid = 1'b1; op_sel = 2'b10; rs_val = 32'h1234;
        @(negedge clk);
        if (busy) busy_seen++;
        op_sel = 2'b11; rs_val = 32'h5678;
        @(negedge clk);
        if (busy) busy_seen++;
        op_valid = 1'b0;
        @(negedge clk);
        if (busy) busy_seen++;
        total++;
        if (busy_seen !== 0) begin bad++; $display("FAIL b2b_busy: busy seen %0d cycles want 0", busy_seen); end
        e = exp_q.pop_front();
        total++;
        if ({hi, lo} !== e) begin bad++; $display("FAIL b2b_hilo: got %h want %h", {hi, lo}, e); end
    endtask

    task automatic test_reset_mid_div();
        issue(2'b01, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        total++;
        if (busy !== 1'b1 || div_start !== 1'b1) begin
            bad++; $display("FAIL mid_running: busy=%b dstart=%b want 1 1", busy, div_start);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || div_start !== 1'b0 || {hi, lo} !== 64'd0) begin
            bad++; $display("FAIL mid_reset: busy=%b dstart=%b hilo=%h want 0 0 0", busy, div_start, {hi, lo});
        end
        repeat (40) @(negedge clk);
        total++;
        if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
            bad++; $display("FAIL mid_discard: busy=%b hilo=%h want 0 0", busy, {hi, lo});
        end
    endtask

    initial begin
        test_reset();
        test_div();
        test_div_zero();
        test_mult_busy_ignore();
        test_timeout();
        test_end_and_timeout();
        test_back_to_back();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Sequencer and HI/LO register file between the multicycle control unit and the iterative MULT/DIV datapaths.
- Accepts one MULT/DIV/MTHI/MTLO request at a time and latches operands.
- Holds the unit start line high until the unit reports end, then captures results into architectural HI/LO.
- Flags divide-by-zero and hung units; gives control a busy/stall signal for MFHI/MFLO.

Parameters:
TIMEOUT, 40, max posedges a unit may run before abort (divider needs 32; must be >32)
CNT_W, 8, width of run-cycle counter (2^CNT_W > TIMEOUT)

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high; sampled on posedge clk
op_valid  in  1  request strobe from control, one cycle
op_sel  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
rs_val  in  32  operand A (dividend / multiplicand / MT source)
rt_val  in  32  operand B (divisor / multiplier)
op_ready  out  1  1 = request accepted this cycle if op_valid
busy  out  1  1 while a MULT/DIV is in flight (control stalls MFHI/MFLO)
opa  out  32  registered operand A to both units
opb  out  32  registered operand B to both units
div_start  out  1  level start to divider
div_end  in  1  divider done (level)
div_hi  in  32  divider remainder
div_lo  in  32  divider quotient
mult_start  out  1  level start to multiplier
mult_end  in  1  multiplier done (level)
mult_hi  in  32  product upper word
mult_lo  in  32  product lower word
hi  out  32  architectural HI
lo  out  32  architectural LO
div_zero_exc  out  1  one-cycle pulse: DIV with rt_val==0
timeout_err  out  1  one-cycle pulse: unit exceeded TIMEOUT

Behaviour:
- Reset (posedge with reset=1, any state): state=IDLE; hi, lo, opa, opb = 0; div_start, mult_start, div_zero_exc, timeout_err = 0; counter = 0. Mid-run reset drops start the same edge and discards the result.
- op_ready = (state==IDLE); busy = (state!=IDLE). Both are combinational from state. op_valid while busy is ignored (not queued).
- IDLE, op_valid=1:
  - MTHI: hi<=rs_val next edge; stay IDLE.
  - MTLO: lo<=rs_val next edge; stay IDLE.
  - DIV with rt_val==0: div_zero_exc=1 for one cycle; hi/lo unchanged; divider never started; stay IDLE.
  - DIV otherwise: opa<=rs_val, opb<=rt_val, div_start<=1, counter<=0, go RUN_DIV.
  - MULT: opa<=rs_val, opb<=rt_val, mult_start<=1, counter<=0, go RUN_MULT.
- RUN_DIV / RUN_MULT:
  - Each posedge: counter<=counter+1.
  - Unit end is valid from the first posedge after start rose. The divider updates on negedge and clears a stale end in that first half-cycle, so a sticky end from a prior op is never sampled.
  - End seen (div_end or mult_end per state): start<=0; hi/lo <= unit hi/lo on that same edge; go IDLE. Latency: request edge to HI/LO update = unit cycles + 1. Nominal DIV = 33 posedges.
  - counter==TIMEOUT-1 without end: start<=0, timeout_err pulse 1 cycle, hi/lo unchanged, go IDLE.
  - End and timeout on the same edge: end wins, no error.
- Start must drop on the capture edge. The divider keeps iterating while start stays high.
- opa/opb are held stable for the whole run.
- Only one start is high at any time. Both are 0 in IDLE.
- The block does no sign handling or arithmetic. Results pass through unchanged.

Test Plan:
- Reset mid-RUN_DIV (cycle 10) -> next edge state IDLE, div_start=0, hi=lo=0, busy=0.
- DIV rs=100, rt=7, divider model end after 32 cycles -> div_start high exactly 32 cycles; hi=2, lo=14 one edge after end; busy falls with it; op_ready=1 next cycle.
- DIV rs=5, rt=0 -> div_zero_exc single-cycle pulse, div_start never 1, hi/lo keep prior values (preload via MTHI 0xAAAA_AAAA, MTLO 0x5555_5555).
- MULT rs=0xFFFF_FFFF, rt=2, multiplier returns hi=0xFFFF_FFFF, lo=0xFFFF_FFFE -> captured; then a second op_valid issued while busy is ignored, and hi/lo reflect only the first op.
- Unit model never asserts end -> timeout_err pulse at counter TIMEOUT-1 (edge 40), start dropped, hi/lo unchanged, op_ready=1 next cycle.
- Back-to-back MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, busy never 1.
